// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default register file geometry and the
// register-number type used by the decoder and the register file.
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_DEPTH  = 8;
    localparam int CPU_ADDR_W = $clog2(CPU_DEPTH);

    // Register number as produced by the instruction decoder.
    typedef logic [CPU_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file. Tracks in-flight destination
// registers, refuses reservations of registers still in flight, reports
// read hazards and keeps a registered population count of busy bits.
// A write in the same cycle releases its register first, so a reservation
// or read of that register sees it free (release-then-reserve).
module rf_scoreboard #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              write,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              rsv_stall,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic [DEPTH-1:0] rel_vec;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] busy_eff;
    logic [ADDR_W:0]  cnt_reg;
    logic [ADDR_W:0]  cnt_next;
    logic             stall_raw;
    logic             rsv_ok;
    logic             inc;
    logic             dec;

    // Refusal is decided against the busy view after this cycle's release.
    assign stall_raw = reserve & busy_eff[rsv_addr];
    assign rsv_ok    = reserve & ~stall_raw;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bits
            assign rel_vec[gi]  = write && (waddr == ADDR_W'(gi));
            assign busy_eff[gi] = busy_reg[gi] & ~rel_vec[gi];
            // A hardwired-zero register accepts reservations but never goes busy.
            if (ZERO_REG && gi == 0) begin : g_zero
                assign set_vec[gi] = 1'b0;
            end else begin : g_norm
                assign set_vec[gi] = rsv_ok && (rsv_addr == ADDR_W'(gi));
            end
        end
    endgenerate

    // An accepted reservation always sets a bit that is clear after release,
    // and a write only lowers the count when it frees a bit that was set.
    assign inc       = |set_vec;
    assign dec       = write & busy_reg[waddr];
    assign busy_next = busy_eff | set_vec;
    assign cnt_next  = cnt_reg + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};

    // Busy vector and busy count update; reset clears both.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    // Hazard and stall flags are suppressed while reset is held.
    assign busy1     = ~RESET & busy_eff[rd1_addr];
    assign busy2     = ~RESET & busy_eff[rd2_addr];
    assign rsv_stall = ~RESET & stall_raw;
    assign busy_cnt  = cnt_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with integrated scoreboard: DEPTH x DATA_W storage, two
// combinational read ports with optional write bypass, one synchronous write
// port, optional hardwired-zero register 0, and busy-bit hazard tracking.
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int  DATA_W   = CPU_DATA_W,
    parameter int  DEPTH    = CPU_DEPTH,
    parameter bit  BYPASS   = 1'b1,
    parameter bit  ZERO_REG = 1'b0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              BUSY1,
    output logic              BUSY2,
    input  logic              RESERVE,
    input  logic [ADDR_W-1:0] RSVADDRESS,
    output logic              RSV_STALL,
    output logic [ADDR_W:0]   BUSY_CNT
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              wr_en;

    // Writes to a hardwired-zero register 0 are dropped.
    assign wr_en = WRITE && !(ZERO_REG && INADDRESS == '0);

    // Storage update; every register is cleared on reset so reads return 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[INADDRESS] <= IN;
        end
    end

    // Read port 1: stored value, then bypass, then the zero-register override.
    always_comb begin
        OUT1 = mem_reg[OUT1ADDRESS];
        if (BYPASS && WRITE && OUT1ADDRESS == INADDRESS) begin
            OUT1 = IN;
        end
        if (ZERO_REG && OUT1ADDRESS == '0) begin
            OUT1 = '0;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        OUT2 = mem_reg[OUT2ADDRESS];
        if (BYPASS && WRITE && OUT2ADDRESS == INADDRESS) begin
            OUT2 = IN;
        end
        if (ZERO_REG && OUT2ADDRESS == '0) begin
            OUT2 = '0;
        end
    end

    rf_scoreboard #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_sb (
        .CLK      (CLK),
        .RESET    (RESET),
        .write    (WRITE),
        .waddr    (INADDRESS),
        .reserve  (RESERVE),
        .rsv_addr (RSVADDRESS),
        .rd1_addr (OUT1ADDRESS),
        .rd2_addr (OUT2ADDRESS),
        .busy1    (BUSY1),
        .busy2    (BUSY2),
        .rsv_stall(RSV_STALL),
        .busy_cnt (BUSY_CNT)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: one instance with ZERO_REG=0 and one
// with ZERO_REG=1 share the same stimulus. A directed vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_reg_file_sb;

    logic       CLK;
    logic       RESET;
    logic       WRITE;
    logic [2:0] INADDRESS;
    logic [7:0] IN;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic       RESERVE;
    logic [2:0] RSVADDRESS;

    logic [7:0] o1 [2];
    logic [7:0] o2 [2];
    logic       b1 [2];
    logic       b2 [2];
    logic       st [2];
    logic [3:0] cnt [2];

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state, one copy per instance (index = ZERO_REG).
    logic [7:0] m_mem  [2][8];
    bit         m_busy [2][8];

    reg_file_sb #(.DATA_W(8), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(o1[0]), .OUT2(o2[0]), .BUSY1(b1[0]), .BUSY2(b2[0]),
        .RESERVE(RESERVE), .RSVADDRESS(RSVADDRESS), .RSV_STALL(st[0]), .BUSY_CNT(cnt[0])
    );

    reg_file_sb #(.DATA_W(8), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(o1[1]), .OUT2(o2[1]), .BUSY1(b1[1]), .BUSY2(b2[1]),
        .RESERVE(RESERVE), .RSVADDRESS(RSVADDRESS), .RSV_STALL(st[1]), .BUSY_CNT(cnt[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [2:0] wa;
        logic [7:0] din;
        logic       rsv;
        logic [2:0] ra;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       eb1;
        logic       eb2;
        logic       es;
        logic [3:0] ecnt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wr, input logic [2:0] wa, input logic [7:0] din,
                         input logic rsv, input logic [2:0] ra, input logic [2:0] a1, input logic [2:0] a2);
        RESET = rst; WRITE = wr; INADDRESS = wa; IN = din;
        RESERVE = rsv; RSVADDRESS = ra; OUT1ADDRESS = a1; OUT2ADDRESS = a2;
    endtask

    // Inputs change 1 after posedge; combinational outputs settle, checked 3 later.
    task automatic settle();
        #3;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] m_read(int z, logic [2:0] a);
        if (z == 1 && a == 3'd0) return 8'h00;
        if (WRITE && a == INADDRESS) return IN;
        return m_mem[z][a];
    endfunction

    function automatic logic m_busy_now(int z, logic [2:0] a);
        return m_busy[z][a] && !(WRITE && INADDRESS == a);
    endfunction

    function automatic logic [3:0] m_count(int z);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_busy[z][i]);
        return 4'(c);
    endfunction

    // Compare combinational outputs with the model, then advance the model
    // by the rules of one clock edge.
    task automatic model_cycle();
        logic st_e;
        for (int z = 0; z < 2; z++) begin
            st_e = !RESET && RESERVE && m_busy_now(z, RSVADDRESS);
            chk($sformatf("rnd out1 z%0d", z), o1[z], m_read(z, OUT1ADDRESS));
            chk($sformatf("rnd out2 z%0d", z), o2[z], m_read(z, OUT2ADDRESS));
            chk($sformatf("rnd busy1 z%0d", z), b1[z], !RESET && m_busy_now(z, OUT1ADDRESS));
            chk($sformatf("rnd busy2 z%0d", z), b2[z], !RESET && m_busy_now(z, OUT2ADDRESS));
            chk($sformatf("rnd stall z%0d", z), st[z], st_e);
            if (RESET) begin
                for (int i = 0; i < 8; i++) begin
                    m_mem[z][i] = 8'h00;
                    m_busy[z][i] = 1'b0;
                end
            end else begin
                if (WRITE) begin
                    if (!(z == 1 && INADDRESS == 3'd0)) m_mem[z][INADDRESS] = IN;
                    m_busy[z][INADDRESS] = 1'b0;
                end
                if (RESERVE && !st_e && !(z == 1 && RSVADDRESS == 3'd0))
                    m_busy[z][RSVADDRESS] = 1'b1;
            end
        end
    endtask

    function automatic vec_t mk(logic rst, logic wr, logic [2:0] wa, logic [7:0] din, logic rsv,
                                logic [2:0] ra, logic [2:0] a1, logic [2:0] a2, logic [7:0] e1,
                                logic [7:0] e2, logic eb1, logic eb2, logic es, logic [3:0] ecnt);
        vec_t v;
        v.rst = rst; v.wr = wr; v.wa = wa; v.din = din; v.rsv = rsv; v.ra = ra;
        v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
        v.es = es; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        //             rst wr  wa  din    rsv ra  a1  a2  e1     e2     b1 b2 st cnt
        vecs[0]  = mk(0, 1, 3, 8'h5A, 0, 0, 3, 3, 8'h5A, 8'h5A, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 8'h00, 1, 1, 3, 1, 8'h5A, 8'h00, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 8'h00, 0, 0, 3, 5, 8'h00, 8'h00, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 5, 8'hA7, 0, 0, 5, 5, 8'hA7, 8'hA7, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 8'h00, 0, 0, 5, 5, 8'hA7, 8'hA7, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 8'h00, 1, 2, 2, 5, 8'h00, 8'hA7, 0, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 8'h00, 1, 2, 2, 2, 8'h00, 8'h00, 1, 1, 1, 1);
        vecs[7]  = mk(0, 1, 2, 8'h11, 0, 0, 2, 5, 8'h11, 8'hA7, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 8'h00, 1, 4, 4, 2, 8'h00, 8'h11, 0, 0, 0, 1);
        vecs[9]  = mk(0, 1, 4, 8'h3C, 1, 4, 4, 4, 8'h3C, 8'h3C, 0, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 8'h00, 0, 0, 4, 2, 8'h3C, 8'h11, 1, 0, 0, 1);
        vecs[11] = mk(0, 1, 7, 8'hC3, 1, 7, 7, 4, 8'hC3, 8'h3C, 0, 1, 0, 2);

        // Power-on reset.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        tick();
        drive(0, 0, 0, 0, 0, 0, 3, 6);
        settle();
        for (int z = 0; z < 2; z++) begin
            chk($sformatf("reset cnt z%0d", z), cnt[z], 4'd0);
            chk($sformatf("reset out1 z%0d", z), o1[z], 8'h00);
            chk($sformatf("reset stall z%0d", z), st[z], 1'b0);
        end
        tick();

        // Directed table on the ZERO_REG=0 instance.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].wa, vecs[i].din,
                  vecs[i].rsv, vecs[i].ra, vecs[i].a1, vecs[i].a2);
            settle();
            chk($sformatf("vec%0d out1", i), o1[0], vecs[i].e1);
            chk($sformatf("vec%0d out2", i), o2[0], vecs[i].e2);
            chk($sformatf("vec%0d busy1", i), b1[0], vecs[i].eb1);
            chk($sformatf("vec%0d busy2", i), b2[0], vecs[i].eb2);
            chk($sformatf("vec%0d stall", i), st[0], vecs[i].es);
            tick();
            chk($sformatf("vec%0d cnt", i), cnt[0], vecs[i].ecnt);
            $display("vector %0d applied: wr=%0b wa=%0d rsv=%0b ra=%0d cnt=%0d",
                     i, vecs[i].wr, vecs[i].wa, vecs[i].rsv, vecs[i].ra, cnt[0]);
        end

        // Zero register: writes dropped and bypass overridden, reservation accepted.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 8'hFF, 0, 0, 0, 0);
        settle();
        chk("zero bypass z1", o1[1], 8'h00);
        chk("zero bypass z0", o1[0], 8'hFF);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        settle();
        chk("zero read z1", o1[1], 8'h00);
        chk("zero read z0", o1[0], 8'hFF);
        chk("zero rsv stall z1", st[1], 1'b0);
        tick();
        chk("zero rsv cnt z1", cnt[1], 4'd0);
        chk("zero rsv cnt z0", cnt[0], 4'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("zero busy z1", b1[1], 1'b0);
        chk("zero busy z0", b1[0], 1'b1);
        $display("zero register sequence done");

        // Fill the scoreboard, then reset over a concurrent write and reserve.
        for (int a = 1; a < 8; a++) begin
            drive(0, 0, 0, 0, 1, 3'(a), 0, 0);
            tick();
        end
        chk("full cnt z0", cnt[0], 4'd8);
        chk("full cnt z1", cnt[1], 4'd7);
        drive(0, 0, 0, 0, 1, 3, 0, 0);
        settle();
        chk("full stall z1", st[1], 1'b1);
        tick();
        chk("full hold cnt z0", cnt[0], 4'd8);
        drive(1, 1, 6, 8'h99, 1, 5, 5, 2);
        settle();
        for (int z = 0; z < 2; z++) begin
            chk($sformatf("rst stall z%0d", z), st[z], 1'b0);
            chk($sformatf("rst busy1 z%0d", z), b1[z], 1'b0);
        end
        tick();
        for (int z = 0; z < 2; z++) chk($sformatf("post rst cnt z%0d", z), cnt[z], 4'd0);
        for (int a = 0; a < 8; a++) begin
            drive(0, 0, 0, 0, 0, 0, 3'(a), 3'(a));
            settle();
            for (int z = 0; z < 2; z++) begin
                chk($sformatf("post rst r%0d out z%0d", a, z), o1[z], 8'h00);
                chk($sformatf("post rst r%0d busy z%0d", a, z), b2[z], 1'b0);
            end
            tick();
        end
        $display("reset mid-operation sequence done");

        // Randomized run against the model.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < 8; i++) begin
                m_mem[z][i] = 8'h00;
                m_busy[z][i] = 1'b0;
            end
        tick();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if (n % 2 == 1) INADDRESS = RSVADDRESS;
            settle();
            model_cycle();
            tick();
            for (int z = 0; z < 2; z++)
                chk($sformatf("rnd cnt z%0d n%0d", z, n), cnt[z], m_count(z));
            $display("rnd %0d: rst=%0b wr=%0b wa=%0d rsv=%0b ra=%0d cnt0=%0d cnt1=%0d",
                     n, RESET, WRITE, INADDRESS, RESERVE, RSVADDRESS, cnt[0], cnt[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
